// File: rtl/msk_rnd_feeder.sv
`default_nettype none
// ============================================================================
// Module   : msk_rnd_feeder
// Brief    : Randomness producer for masked gadgets. A 64-bit maximal-length
//            LFSR (x^64+x^63+x^61+x^60+1) is seeded with two 32-bit words,
//            warmed up, then streams RND_W fresh bits per valid/ready transfer.
// Revision : 1.0 - initial release
// ============================================================================
module msk_rnd_feeder #(
   parameter int RND_W  = 4,   // random bits per transfer, 1..32
   parameter int WARMUP = 32   // LFSR advances discarded after seeding
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [31:0]      seed_in,
   input  logic             seed_valid,
   output logic             seed_ready,
   output logic [RND_W-1:0] rnd,
   output logic             rnd_valid,
   input  logic             rnd_ready,
   output logic             busy
);

   // Warm-up counter must hold the value WARMUP; keep at least one bit.
   localparam int c_cnt_w = (WARMUP < 2) ? 1 : $clog2(WARMUP + 1);

   localparam logic [1:0] c_st_idle = 2'd0;  // waiting for low seed word
   localparam logic [1:0] c_st_seed = 2'd1;  // waiting for high seed word
   localparam logic [1:0] c_st_warm = 2'd2;  // discarding warm-up advances
   localparam logic [1:0] c_st_run  = 2'd3;  // streaming random bits

   logic [1:0]         state_q, state_d;
   logic [63:0]        lfsr_q, lfsr_d;
   logic [c_cnt_w-1:0] warm_cnt_q, warm_cnt_d;
   logic [63:0]        w_adv;
   logic [63:0]        w_seed_full;

   // Single Fibonacci step: shift left, feed back taps 63/62/60/59 into bit 0.
   function automatic logic [63:0] lfsr_step(input logic [63:0] s);
      return {s[62:0], s[63] ^ s[62] ^ s[60] ^ s[59]};
   endfunction

   // One advance = RND_W steps unrolled, so each transfer sees all-new bits.
   always_comb begin
      w_adv = lfsr_q;
      for (int i = 0; i < RND_W; i++) begin
         w_adv = lfsr_step(w_adv);
      end
   end

   // Full seed formed from the incoming high word; the all-zero lock-up state
   // is avoided by forcing bit 0.
   always_comb begin
      w_seed_full = {seed_in, lfsr_q[31:0]};
      if (w_seed_full == 64'h0) begin
         w_seed_full[0] = 1'b1;
      end
   end

   // Next-state logic for the FSM, the LFSR and the warm-up counter.
   always_comb begin
      state_d    = state_q;
      lfsr_d     = lfsr_q;
      warm_cnt_d = warm_cnt_q;
      case (state_q)
         c_st_idle: begin
            if (seed_valid) begin
               lfsr_d[31:0] = seed_in;
               state_d      = c_st_seed;
            end
         end
         c_st_seed: begin
            if (seed_valid) begin
               lfsr_d = w_seed_full;
               if (WARMUP == 0) begin
                  state_d = c_st_run;
               end else begin
                  warm_cnt_d = c_cnt_w'(WARMUP);
                  state_d    = c_st_warm;
               end
            end
         end
         c_st_warm: begin
            lfsr_d = w_adv;
            if (warm_cnt_q == c_cnt_w'(1)) begin
               warm_cnt_d = '0;
               state_d    = c_st_run;
            end else begin
               warm_cnt_d = warm_cnt_q - c_cnt_w'(1);
            end
         end
         c_st_run: begin
            // A concurrent transfer completes first; the seed word then
            // overwrites the low half of the advanced state.
            if (rnd_ready) begin
               lfsr_d = w_adv;
            end
            if (seed_valid) begin
               lfsr_d[31:0] = seed_in;
               state_d      = c_st_seed;
            end
         end
         default: begin
            state_d = c_st_idle;
         end
      endcase
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= c_st_idle;
         lfsr_q     <= 64'h0;
         warm_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         lfsr_q     <= lfsr_d;
         warm_cnt_q <= warm_cnt_d;
      end
   end

   // Outputs decode registered state only, keeping handshakes free of
   // combinational paths from the partner's valid/ready.
   assign seed_ready = (state_q != c_st_warm);
   assign rnd_valid  = (state_q == c_st_run);
   assign busy       = (state_q == c_st_seed) || (state_q == c_st_warm);
   assign rnd        = lfsr_q[RND_W-1:0];

endmodule
`default_nettype wire

// File: tb/tb_msk_rnd_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_msk_rnd_feeder
// Brief    : Self-checking bench for msk_rnd_feeder with a scoreboard queue and
//            a reference LFSR model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_msk_rnd_feeder;

   localparam int RND_W  = 4;
   localparam int WARMUP = 32;

   logic             clk;
   logic             rst_n;
   logic [31:0]      seed_in;
   logic             seed_valid;
   logic             seed_ready;
   logic [RND_W-1:0] rnd;
   logic             rnd_valid;
   logic             rnd_ready;
   logic             busy;

   int checks = 0;
   int errors = 0;

   logic [RND_W-1:0] exp_q[$];
   logic [63:0]      m;          // reference generator state
   logic [RND_W-1:0] acc;

   msk_rnd_feeder #(.RND_W(RND_W), .WARMUP(WARMUP)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .seed_in   (seed_in),
      .seed_valid(seed_valid),
      .seed_ready(seed_ready),
      .rnd       (rnd),
      .rnd_valid (rnd_valid),
      .rnd_ready (rnd_ready),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Reference generator: the polynomial x^64+x^63+x^61+x^60+1, stepped
   // bit by bit; each output word consumes RND_W fresh steps.
   task automatic m_advance();
      for (int i = 0; i < RND_W; i++) begin
         m = {m[62:0], m[63] ^ m[62] ^ m[60] ^ m[59]};
      end
   endtask

   task automatic m_seed(input logic [31:0] lo, input logic [31:0] hi);
      m = {hi, lo};
      if (m == 64'h0) m = 64'h1;
      for (int i = 0; i < WARMUP; i++) m_advance();
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard monitor: every accepted transfer must match the next expected word.
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n && rnd_valid && rnd_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL sb_unexpected actual=%0h expected=none", rnd);
            end else begin
               logic [RND_W-1:0] e;
               e = exp_q.pop_front();
               if (rnd !== e) begin
                  errors++;
                  $display("FAIL sb_rnd actual=%0h expected=%0h", rnd, e);
               end
            end
         end
      end
   end

   // Two-word seed load from IDLE (or RUN without a concurrent transfer).
   task automatic load_seed(input logic [31:0] lo, input logic [31:0] hi);
      rnd_ready  = 1'b0;
      seed_valid = 1'b1;
      seed_in    = lo;
      cyc();
      seed_in    = hi;
      cyc();
      seed_valid = 1'b0;
      seed_in    = 32'h0;
      m_seed(lo, hi);
   endtask

   // Bounded wait for RUN; returns number of cycles busy was observed.
   task automatic wait_run(input string name, output int busy_cnt);
      busy_cnt = 0;
      for (int i = 0; i < 200 && !rnd_valid; i++) begin
         if (busy) busy_cnt++;
         cyc();
      end
      chk({name, "_reach_run"}, {63'h0, rnd_valid}, 64'h1);
   endtask

   // Random-ready stream: each ready cycle in RUN is a transfer.
   task automatic run_stream(input int n, input int pct);
      acc = '0;
      for (int i = 0; i < n; i++) begin
         rnd_ready = ($urandom_range(0, 99) < pct);
         if (rnd_ready) begin
            exp_q.push_back(m[RND_W-1:0]);
            acc |= rnd;
            m_advance();
         end
         cyc();
      end
      rnd_ready = 1'b0;
      cyc();
      chk("sb_drained", exp_q.size(), 0);
   endtask

   initial begin
      int bc;
      logic [RND_W-1:0] held;
      rst_n      = 1'b0;
      seed_in    = 32'h0;
      seed_valid = 1'b0;
      rnd_ready  = 1'b0;
      m          = 64'h0;

      // Reset state while held in reset.
      repeat (3) cyc();
      chk("rst_seed_ready", seed_ready, 1);
      chk("rst_rnd_valid", rnd_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_rnd", rnd, 0);
      rst_n = 1'b1;
      cyc();

      // Seed 1/0: busy for exactly SEED + WARMUP cycles, then a golden stream.
      rnd_ready  = 1'b0;
      seed_valid = 1'b1;
      seed_in    = 32'h1;
      cyc();
      bc = busy ? 1 : 0;
      seed_in = 32'h0;
      cyc();
      seed_valid = 1'b0;
      m_seed(32'h1, 32'h0);
      begin
         int w;
         wait_run("t2", w);
         bc += w;
      end
      chk("t2_busy_cycles", bc, WARMUP + 1);
      chk("t2_busy_low", busy, 0);
      run_stream(100, 100);

      // All-zero seed forced to 1.
      load_seed(32'h0, 32'h0);
      chk("t3_forced_state", dut.lfsr_q, 64'h1);
      wait_run("t3", bc);
      run_stream(64, 100);
      chk("t3_not_all_zero", {63'h0, acc != 0}, 64'h1);

      // Stall: rnd must hold while rnd_ready is low, then resume in order.
      load_seed($urandom, $urandom);
      wait_run("t4", bc);
      run_stream(20, 60);
      held = m[RND_W-1:0];
      for (int i = 0; i < 10; i++) begin
         chk("t4_stall_rnd", rnd, held);
         chk("t4_stall_valid", rnd_valid, 1);
         cyc();
      end
      run_stream(40, 70);

      // Reseed during RUN with a concurrent transfer.
      rnd_ready  = 1'b1;
      seed_valid = 1'b1;
      seed_in    = 32'hDEADBEEF;
      exp_q.push_back(m[RND_W-1:0]);
      m_advance();
      cyc();
      chk("t5_valid_drop", rnd_valid, 0);
      chk("t5_busy", busy, 1);
      rnd_ready = 1'b0;
      seed_in   = 32'h12345678;
      cyc();
      seed_valid = 1'b0;
      m_seed(32'hDEADBEEF, 32'h12345678);
      wait_run("t5", bc);
      run_stream(50, 80);

      // Reset during warm-up, then a clean restart.
      rnd_ready  = 1'b0;
      seed_valid = 1'b1;
      seed_in    = 32'hCAFEF00D;
      cyc();
      seed_in = 32'h0BADC0DE;
      cyc();
      seed_valid = 1'b0;
      repeat (5) cyc();
      chk("t6_in_warm", busy, 1);
      rst_n = 1'b0;
      #1;
      chk("t6_rst_valid", rnd_valid, 0);
      chk("t6_rst_lfsr", dut.lfsr_q, 64'h0);
      chk("t6_rst_seed_ready", seed_ready, 1);
      chk("t6_rst_busy", busy, 0);
      cyc();
      rst_n = 1'b1;
      cyc();
      load_seed(32'h89ABCDEF, 32'h01234567);
      wait_run("t6", bc);
      run_stream(50, 50);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Global time limit so the run always ends.
   initial begin
      #500000;
      $display("FAIL timeout actual=running expected=finished");
      $fatal(1);
   end

endmodule
`default_nettype wire
